// File: rtl/uno_hand_scheduler_if.sv
// Card write port for uno_hand_scheduler: a valid/ready channel carrying one
// slot's {present, number, color} update into the shadow bank.
interface uno_hand_scheduler_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_slot;
    logic       wr_present;
    logic [3:0] wr_number;
    logic [1:0] wr_color;

    modport master (
        output wr_valid, wr_slot, wr_present, wr_number, wr_color,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_slot, wr_present, wr_number, wr_color,
        output wr_ready
    );
endinterface

// File: rtl/uno_hand_scheduler.sv
// Shares one glyph renderer across the hand row: tracks the beam along the row and presents the
// slot under it one cycle ahead. Define HAND_BLINK_EN to blink the selected slot every BLINK_FRAMES frames.
module uno_hand_scheduler #(
    parameter int SLOTS        = 8,
    parameter int HAND_X0      = 40,
    parameter int HAND_Y0      = 400,
    parameter int PITCH        = 70,
    parameter int GLYPH_W      = 31,
    parameter int GLYPH_H      = 51,
    parameter int V_ACTIVE     = 480,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            x_cnt,
    input  logic [9:0]            y_cnt,
    uno_hand_scheduler_if.slave   wr,
    input  logic [2:0]            sel_slot,
    output logic [9:0]            x_pin,
    output logic [9:0]            y_pin,
    output logic [1:0]            color,
    output logic [3:0]            glyph_num,
    output logic [2:0]            slot_idx,
    output logic                  glyph_en,
    output logic                  frame_start
);

    typedef struct packed {
        logic       present;
        logic [3:0] number;
        logic [1:0] color;
    } card_t;

    typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

    card_t  shadow_reg [SLOTS];
    card_t  active_reg [SLOTS];
    state_t state_reg;
    logic [9:0] pcnt_reg;
    logic       wr_ready_reg;

    logic       commit_seen;
    logic       wr_fire;
    logic       in_window;
    logic       line_start;
    logic       last_pitch;
    logic       last_slot;
    logic [2:0] next_idx;
    logic [7:0] hide_mask;
    card_t      first_card;
    card_t      cur_card;
    card_t      next_card;

    function automatic logic card_visible(input card_t c);
        return c.present && (c.number <= 4'd9);
    endfunction

    assign commit_seen = (x_cnt == 10'd0) && (y_cnt == 10'(V_ACTIVE));
    assign wr_fire     = wr.wr_valid && wr_ready_reg;
    assign wr.wr_ready = wr_ready_reg;

    assign in_window  = (y_cnt >= 10'(HAND_Y0)) && (y_cnt <= 10'(HAND_Y0 + GLYPH_H - 1));
    assign line_start = (x_cnt == 10'(HAND_X0 - 1)) && in_window;
    assign last_pitch = (pcnt_reg == 10'(PITCH - 1));
    assign last_slot  = (slot_idx == 3'(SLOTS - 1));
    assign next_idx   = last_slot ? slot_idx : slot_idx + 3'd1;

    assign first_card = active_reg[0];
    assign cur_card   = active_reg[slot_idx];
    assign next_card  = active_reg[next_idx];

    // Commit runs in the cycle after (0, V_ACTIVE) is seen; the port is held off
    // for that one cycle so a write can never race the bank copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
            frame_start  <= 1'b0;
            wr_ready_reg <= 1'b0;
        end else begin
            frame_start  <= commit_seen;
            wr_ready_reg <= !commit_seen;
            if (frame_start) begin
                for (int i = 0; i < SLOTS; i++) begin
                    active_reg[i] <= shadow_reg[i];
                end
            end
            if (wr_fire && (int'(wr.wr_slot) < SLOTS)) begin
                shadow_reg[wr.wr_slot] <= '{present: wr.wr_present,
                                            number:  wr.wr_number,
                                            color:   wr.wr_color};
            end
        end
    end

`ifdef HAND_BLINK_EN
    localparam int BCW = $clog2(BLINK_FRAMES + 1);

    logic [BCW-1:0] blink_cnt_reg;
    logic           blink_phase_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt_reg == BCW'(BLINK_FRAMES - 1)) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= !blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    assign hide_mask = blink_phase_reg ? (8'd1 << sel_slot) : 8'd0;
`else
    logic unused_cfg;
    assign unused_cfg = ^{sel_slot, 32'(BLINK_FRAMES)};
    assign hide_mask  = 8'd0;
`endif

    // Outputs are loaded with the values for the column that follows the sampled one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            pcnt_reg  <= '0;
            slot_idx  <= '0;
            x_pin     <= '0;
            y_pin     <= '0;
            color     <= '0;
            glyph_num <= '0;
            glyph_en  <= 1'b0;
        end else begin
            glyph_en <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (line_start) begin
                        state_reg <= TRACK;
                        pcnt_reg  <= '0;
                        slot_idx  <= '0;
                        x_pin     <= 10'(HAND_X0);
                        y_pin     <= 10'(HAND_Y0);
                        color     <= first_card.color;
                        glyph_num <= first_card.number;
                        glyph_en  <= card_visible(first_card) && !hide_mask[0];
                    end
                end
                TRACK: begin
                    if (last_pitch) begin
                        pcnt_reg <= '0;
                        if (last_slot) begin
                            state_reg <= DONE;
                        end else begin
                            slot_idx  <= next_idx;
                            x_pin     <= x_pin + 10'(PITCH);
                            color     <= next_card.color;
                            glyph_num <= next_card.number;
                            glyph_en  <= card_visible(next_card) && !hide_mask[next_idx];
                        end
                    end else begin
                        pcnt_reg <= pcnt_reg + 10'd1;
                        glyph_en <= (pcnt_reg + 10'd1 < 10'(GLYPH_W))
                                    && card_visible(cur_card) && !hide_mask[slot_idx];
                    end
                end
                DONE: begin
                    if (x_cnt == 10'd0) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
